// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory stage.
// Contents: RV32I load/store funct3 encodings, FSM state type, access-size
// decode, byte-enable / store-lane helpers and the misalignment predicate.
package lsu_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    localparam int unsigned NumLanes = 4;

    typedef enum logic [1:0] {StIdle, StReq, StResp} lsu_state_e;
    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} lsu_size_e;

    // funct3[1:0] sets the size; 011/110/111 fall through to word.
    function automatic lsu_size_e size_of(logic [1:0] sz);
        case (sz)
            2'b00:   size_of = SzByte;
            2'b01:   size_of = SzHalf;
            default: size_of = SzWord;
        endcase
    endfunction

    // Half accesses look only at addr[1]; words always enable every lane.
    function automatic logic [NumLanes-1:0] lane_be(logic [1:0] sz, logic [1:0] off);
        case (size_of(sz))
            SzByte:  lane_be = 4'b0001 << off;
            SzHalf:  lane_be = off[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    // Replicate store data across lanes so the byte enables alone pick the target.
    function automatic logic [31:0] lane_wdata(logic [1:0] sz, logic [31:0] d);
        case (size_of(sz))
            SzByte:  lane_wdata = {4{d[7:0]}};
            SzHalf:  lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic misaligned(logic [1:0] sz, logic [1:0] off);
        case (size_of(sz))
            SzHalf:  misaligned = off[0];
            SzWord:  misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed byte/half lane from the read
// word and sign- or zero-extends it according to funct3.
// Ports: funct3 (load kind), off (latched addr[1:0]), rdata (bus word),
//        data (extended result).
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        is_signed;

    always_comb begin
        lane_b    = rdata[{off, 3'b000} +: 8];
        lane_h    = off[1] ? rdata[31:16] : rdata[15:0];
        // funct3[2] marks the unsigned variants.
        is_signed = ~funct3[2];
        case (size_of(funct3[1:0]))
            SzByte:  data = {{24{lane_b[7] & is_signed}}, lane_b};
            SzHalf:  data = {{16{lane_h[15] & is_signed}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit, memory stage. Takes the EX/MEM effective address, store
// data and funct3, runs a req/gnt/rvalid handshake to data memory and returns
// extended load data to writeback. Holds the pipeline via lsu_busy.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ex_valid/ex_mem_read/ex_mem_write/ex_funct3/ex_addr/ex_wdata  EX/MEM slot
//   lsu_ready, lsu_busy             accept / stall indications
//   dmem_req/we/addr/be/wdata, dmem_gnt, dmem_rvalid, dmem_rdata  memory bus
//   wb_valid, wb_rdata              load result to writeback
//   misalign, misalign_addr         misaligned-access pulse and address
// Build option: LSU_MISALIGN_TRAP_EN turns misaligned halves/words into a
// misalign pulse with no bus access; otherwise the low address bits are ignored.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    input  logic                ex_mem_read,
    input  logic                ex_mem_write,
    input  logic [2:0]          ex_funct3,
    input  logic [AW-1:0]       ex_addr,
    input  logic [DW-1:0]       ex_wdata,
    output logic                lsu_ready,
    output logic                lsu_busy,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [AW-1:0]       dmem_addr,
    output logic [NumLanes-1:0] dmem_be,
    output logic [DW-1:0]       dmem_wdata,
    input  logic                dmem_gnt,
    input  logic                dmem_rvalid,
    input  logic [DW-1:0]       dmem_rdata,
    output logic                wb_valid,
    output logic [DW-1:0]       wb_rdata,
    output logic                misalign,
    output logic [AW-1:0]       misalign_addr
);

    lsu_state_e          state_q;
    logic                req_q;
    logic                we_q;
    logic [AW-1:0]       addr_q;
    logic [NumLanes-1:0] be_q;
    logic [DW-1:0]       wdata_q;
    logic [2:0]          funct3_q;
    logic [1:0]          off_q;
    logic                wb_valid_q;
    logic [DW-1:0]       wb_rdata_q;
    logic [DW-1:0]       load_data;

    logic accept;
    logic issue;

    assign accept = (state_q == StIdle) & ex_valid & (ex_mem_read | ex_mem_write);

`ifdef LSU_MISALIGN_TRAP_EN
    logic          mis_access;
    logic          misalign_q;
    logic [AW-1:0] misalign_addr_q;

    assign mis_access = accept & misaligned(ex_funct3[1:0], ex_addr[1:0]);
    assign issue      = accept & ~mis_access;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_q <= mis_access;
            if (mis_access) begin
                misalign_addr_q <= ex_addr;
            end
        end
    end

    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;
`else
    assign issue         = accept;
    assign misalign      = 1'b0;
    assign misalign_addr = '0;
`endif

    lsu_load_align u_load_align (
        .funct3 (funct3_q),
        .off    (off_q),
        .rdata  (dmem_rdata),
        .data   (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            off_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rdata_q <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (issue) begin
                        state_q  <= StReq;
                        req_q    <= 1'b1;
                        // A store wins when both read and write are flagged.
                        we_q     <= ex_mem_write;
                        addr_q   <= {ex_addr[AW-1:2], 2'b00};
                        be_q     <= lane_be(ex_funct3[1:0], ex_addr[1:0]);
                        wdata_q  <= lane_wdata(ex_funct3[1:0], ex_wdata);
                        funct3_q <= ex_funct3;
                        off_q    <= ex_addr[1:0];
                    end
                end
                StReq: begin
                    if (dmem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= we_q ? StIdle : StResp;
                    end
                end
                StResp: begin
                    // rvalid only counts here; one arriving with the grant is dropped.
                    if (dmem_rvalid) begin
                        wb_rdata_q <= load_data;
                        wb_valid_q <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign lsu_ready  = (state_q == StIdle);
    assign lsu_busy   = (state_q != StIdle) | accept;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rdata   = wb_rdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic        lsu_ready, lsu_busy;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_rdata;
    logic        misalign;
    logic [31:0] misalign_addr;

    int checks = 0;
    int errors = 0;
    int wb_pulses = 0;
    logic [31:0] sb_q[$];
    logic [31:0] mon_exp;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_wait;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[11];

    lsu_mem_stage u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_funct3     (ex_funct3),
        .ex_addr       (ex_addr),
        .ex_wdata      (ex_wdata),
        .lsu_ready     (lsu_ready),
        .lsu_busy      (lsu_busy),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_rdata      (wb_rdata),
        .misalign      (misalign),
        .misalign_addr (misalign_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every wb_valid pulse must match the oldest pending load.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            wb_pulses++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected actual=%h required=no_pulse", wb_rdata);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("wb_rdata", wb_rdata, mon_exp);
            end
        end
    end

    task automatic drive_access(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr;
        ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata;
        #1;
        chk("ready_on_accept", {31'd0, lsu_ready}, 32'd1);
        chk("busy_on_accept", {31'd0, lsu_busy}, 32'd1);
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    endtask

    // Bounded wait until the scoreboard drains, then confirm the pulse ended.
    task automatic wait_sb();
        int n = 0;
        #1;
        while (sb_q.size() != 0 && n < 8) begin
            @(negedge clk); #1; n++;
        end
        chk("wb_timeout", sb_q.size(), 0);
        sb_q.delete();
        @(negedge clk); #1;
        chk("wb_pulse_len", {31'd0, wb_valid}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        drive_access(v.rd, v.wr, v.f3, v.addr, v.wdata);
        for (int w = 0; w <= v.gnt_wait; w++) begin
            #1;
            chk($sformatf("v%0d_req", idx), {31'd0, dmem_req}, 32'd1);
            chk($sformatf("v%0d_busy", idx), {31'd0, lsu_busy}, 32'd1);
            chk($sformatf("v%0d_addr", idx), dmem_addr, v.exp_addr);
            chk($sformatf("v%0d_be", idx), {28'd0, dmem_be}, {28'd0, v.exp_be});
            chk($sformatf("v%0d_we", idx), {31'd0, dmem_we}, {31'd0, v.wr});
            if (v.wr) chk($sformatf("v%0d_wdata", idx), dmem_wdata, v.exp_wdata);
            dmem_gnt = (w == v.gnt_wait);
            @(negedge clk);
        end
        dmem_gnt = 1'b0;
        if (v.wr) begin
            #1;
            chk($sformatf("v%0d_req_done", idx), {31'd0, dmem_req}, 32'd0);
            chk($sformatf("v%0d_ready_done", idx), {31'd0, lsu_ready}, 32'd1);
            chk($sformatf("v%0d_busy_done", idx), {31'd0, lsu_busy}, 32'd0);
        end else begin
            sb_q.push_back(v.exp_rdata);
            dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
            @(negedge clk);
            dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
            wait_sb();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses_before;
        vec_t v;

        //          rd    wr    f3      addr        wdata         rdata        gw exp_addr    be       exp_wdata     exp_rdata
        vecs[0]  = '{1'b0, 1'b1, 3'b000, 32'h103, 32'h000000AB, 32'h0,        2, 32'h100, 4'b1000, 32'hABABABAB, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h202, 32'h0,        32'h0080FF11, 0, 32'h200, 4'b0100, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h202, 32'h0,        32'h0080FF11, 1, 32'h200, 4'b0100, 32'h0,        32'h00000080};
        vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h402, 32'h0,        32'h80011234, 0, 32'h400, 4'b1100, 32'h0,        32'hFFFF8001};
        vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h402, 32'h0,        32'h80011234, 0, 32'h400, 4'b1100, 32'h0,        32'h00008001};
        vecs[5]  = '{1'b0, 1'b1, 3'b001, 32'h002, 32'h1234BEEF, 32'h0,        0, 32'h000, 4'b1100, 32'hBEEFBEEF, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 3'b010, 32'h020, 32'hDEADBEEF, 32'h0,        1, 32'h020, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h030, 32'h0,        32'hCAFEF00D, 0, 32'h030, 4'b1111, 32'h0,        32'hCAFEF00D};
        vecs[8]  = '{1'b1, 1'b0, 3'b000, 32'h041, 32'h0,        32'h11223344, 0, 32'h040, 4'b0010, 32'h0,        32'h00000033};
        vecs[9]  = '{1'b1, 1'b0, 3'b101, 32'h040, 32'h0,        32'h1122F344, 0, 32'h040, 4'b0011, 32'h0,        32'h0000F344};
        // Read and write both set: the store wins.
        vecs[10] = '{1'b1, 1'b1, 3'b010, 32'h050, 32'h01020304, 32'h0,        0, 32'h050, 4'b1111, 32'h01020304, 32'h0};

        rst_n = 1'b0;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_funct3 = 3'b0; ex_addr = 32'h0; ex_wdata = 32'h0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, lsu_ready}, 32'd1);
        chk("rst_busy", {31'd0, lsu_busy}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], i);
        end

        // ex_valid with neither read nor write is ignored.
        @(negedge clk);
        ex_valid = 1'b1; ex_addr = 32'h80;
        #1;
        chk("nop_busy", {31'd0, lsu_busy}, 32'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        chk("nop_req", {31'd0, dmem_req}, 32'd0);
        chk("nop_ready", {31'd0, lsu_ready}, 32'd1);

        // LW 0x10: rvalid in the grant cycle is ignored, captured three cycles later.
        pulses_before = wb_pulses;
        drive_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hBADBAD00;
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        #1;
        chk("early_rv_no_wb", {31'd0, wb_valid}, 32'd0);
        repeat (2) @(negedge clk);
        sb_q.push_back(32'h12345678);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        wait_sb();
        chk("early_rv_pulses", wb_pulses - pulses_before, 1);

        // Reset while in RESP: outputs clear asynchronously, no wb_valid afterwards.
        pulses_before = wb_pulses;
        drive_access(1'b1, 1'b0, 3'b010, 32'h60, 32'h0);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h55AA55AA;
        #1;
        chk("arst_req", {31'd0, dmem_req}, 32'd0);
        chk("arst_addr", dmem_addr, 32'h0);
        chk("arst_be", {28'd0, dmem_be}, 32'h0);
        chk("arst_wdata", dmem_wdata, 32'h0);
        chk("arst_wb_rdata", wb_rdata, 32'h0);
        chk("arst_busy", {31'd0, lsu_busy}, 32'd0);
        chk("arst_ready", {31'd0, lsu_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("arst_ready_after", {31'd0, lsu_ready}, 32'd1);
        chk("arst_no_wb", wb_pulses - pulses_before, 0);

        // LW 0x6: misaligned word.
`ifdef LSU_MISALIGN_TRAP_EN
        drive_access(1'b1, 1'b0, 3'b010, 32'h6, 32'h0);
        #1;
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_addr", misalign_addr, 32'h6);
        chk("mis_no_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_ready", {31'd0, lsu_ready}, 32'd1);
        @(negedge clk);
        #1;
        chk("mis_pulse_end", {31'd0, misalign}, 32'd0);
        chk("mis_no_req2", {31'd0, dmem_req}, 32'd0);
`else
        v = '{1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 32'hA5A50F0F, 0, 32'h4, 4'b1111, 32'h0, 32'hA5A50F0F};
        run_vec(v, 99);
        chk("mis_tied", {31'd0, misalign}, 32'd0);
        chk("mis_addr_tied", misalign_addr, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
